// File: rtl/spi_frame_master_pkg.sv
// Shared types and constants for the 4-byte SPI register-access frame sequencer.
package spi_frame_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAITRX,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [3:0] CMD_WRITE_NIB = 4'h0;
    localparam logic [3:0] DEF_READ_NIB  = 4'hF;
    localparam int         FRAME_BYTES   = 4;
    localparam int         TMR_W         = 10;

    localparam logic [1:0] SLOT_SYNC = 2'd0;
    localparam logic [1:0] SLOT_CMD  = 2'd1;
    localparam logic [1:0] SLOT_DHI  = 2'd2;
    localparam logic [1:0] SLOT_DLO  = 2'd3;

endpackage

// File: rtl/spi_frame_master_if.sv
// Request/response and byte-engine signals of the SPI frame master.
interface spi_frame_master_if;

    logic        i_req_valid;
    logic        i_req_write;
    logic [3:0]  i_req_addr;
    logic [15:0] i_req_data;
    logic        o_req_ready;
    logic [7:0]  o_TXByte;
    logic        o_TXdv;
    logic        i_TX_ready;
    logic [7:0]  i_RXByte;
    logic        i_RXdv;
    logic        o_CS_n;
    logic        o_rsp_valid;
    logic [7:0]  o_rsp_echo;
    logic [15:0] o_rsp_data;
    logic        o_rsp_err;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_data,
        input  i_TX_ready, i_RXByte, i_RXdv,
        output o_req_ready, o_TXByte, o_TXdv, o_CS_n,
        output o_rsp_valid, o_rsp_echo, o_rsp_data, o_rsp_err
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_data,
        output i_TX_ready, i_RXByte, i_RXdv,
        input  o_req_ready, o_TXByte, o_TXdv, o_CS_n,
        input  o_rsp_valid, o_rsp_echo, o_rsp_data, o_rsp_err
    );

endinterface

// File: rtl/spi_frame_master_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module spi_frame_timer #(
    parameter int W = 10
) (
    input  logic         i_FPGA_clk,
    input  logic         i_FPGA_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
        if (!i_FPGA_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// Sequences one sync/CMDADDR/data-hi/data-lo SPI frame per request and
// returns the echoed CMDADDR and 16-bit read data shifted back by the slave.
module spi_frame_master
    import spi_frame_master_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'h00,
    parameter logic [3:0] READ_NIB  = DEF_READ_NIB,
    parameter int         CS_SETUP  = 2,
    parameter int         CS_HOLD   = 2,
    parameter int         TIMEOUT   = 1023
) (
    input  logic                i_FPGA_clk,
    input  logic                i_FPGA_rst,
    spi_frame_master_if.master  bus
);

    state_t                         state;
    logic [1:0]                     idx;
    logic [7:0]                     cmdaddr;
    logic [15:0]                    wdata;
    logic [FRAME_BYTES-1:0][7:0]    rx_slot;
    logic                           err;

    logic                           tmr_load;
    logic                           tmr_dec;
    logic                           tmr_done;
    logic [TMR_W-1:0]               tmr_val;

    function automatic logic [7:0] slot_byte(input logic [1:0] slot,
                                             input logic [7:0] cmd,
                                             input logic [15:0] data);
        case (slot)
            SLOT_SYNC: return SYNC_BYTE;
            SLOT_CMD:  return cmd;
            SLOT_DHI:  return data[15:8];
            default:   return data[7:0];
        endcase
    endfunction

    spi_frame_timer #(.W(TMR_W)) u_timer (
        .i_FPGA_clk (i_FPGA_clk),
        .i_FPGA_rst (i_FPGA_rst),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .dec        (tmr_dec),
        .done       (tmr_done)
    );

    // One shared timer: loaded with N-1 so each phase lasts exactly N cycles.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (bus.i_req_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(CS_SETUP - 1);
                end
            end
            ST_SEND: begin
                if (bus.i_TX_ready) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT - 1);
                end
            end
            ST_WAITRX: begin
                if ((bus.i_RXdv && idx == SLOT_DLO) || (!bus.i_RXdv && tmr_done)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(CS_HOLD - 1);
                end else if (!bus.i_RXdv) begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SETUP, ST_HOLD: tmr_dec = !tmr_done;
            default: ;
        endcase
    end

    always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
        if (!i_FPGA_rst) begin
            state           <= ST_IDLE;
            idx             <= SLOT_SYNC;
            cmdaddr         <= '0;
            wdata           <= '0;
            rx_slot         <= '0;
            err             <= 1'b0;
            bus.o_CS_n      <= 1'b1;
            bus.o_TXdv      <= 1'b0;
            bus.o_TXByte    <= '0;
            bus.o_req_ready <= 1'b1;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rsp_echo  <= '0;
            bus.o_rsp_data  <= '0;
            bus.o_rsp_err   <= 1'b0;
        end else begin
            bus.o_TXdv      <= 1'b0;
            bus.o_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_req_valid) begin
                        cmdaddr         <= {bus.i_req_write ? CMD_WRITE_NIB : READ_NIB, bus.i_req_addr};
                        wdata           <= bus.i_req_write ? bus.i_req_data : 16'h0000;
                        idx             <= SLOT_SYNC;
                        rx_slot         <= '0;
                        err             <= 1'b0;
                        bus.o_CS_n      <= 1'b0;
                        bus.o_req_ready <= 1'b0;
                        state           <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) state <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.i_TX_ready) begin
                        bus.o_TXByte <= slot_byte(idx, cmdaddr, wdata);
                        bus.o_TXdv   <= 1'b1;
                        state        <= ST_WAITRX;
                    end
                end
                ST_WAITRX: begin
                    if (bus.i_RXdv) begin
                        rx_slot[idx] <= bus.i_RXByte;
                        if (idx == SLOT_DLO) begin
                            state <= ST_HOLD;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= ST_SEND;
                        end
                    end else if (tmr_done) begin
                        // Abandon the remaining slots; they stay zero.
                        err   <= 1'b1;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        bus.o_CS_n      <= 1'b1;
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_echo  <= rx_slot[SLOT_CMD];
                        bus.o_rsp_data  <= {rx_slot[SLOT_DHI], rx_slot[SLOT_DLO]};
                        bus.o_rsp_err   <= err;
                        state           <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.o_req_ready <= 1'b1;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
Master-side frame sequencer for the 4-byte register-access frame used by the FPGA SPI slave: sync byte, CMDADDR, data high, data low. It accepts one write or read request from host logic and drives a byte-level SPI master engine one byte at a time with chip-select framing. It collects the four bytes shifted back during the frame and returns the echoed CMDADDR and the 16-bit read data. It sits between control logic, such as a DAC/ADC sequencer, and the SPI byte engine.

Parameters:
SYNC_BYTE, 8'h00, value sent in byte slot 0.
READ_NIB, 4'hF, CMDADDR upper nibble used for reads; writes always use 4'h0.
CS_SETUP, 2, cycles from o_CS_n falling to the first o_TXdv (range 1..15).
CS_HOLD, 2, cycles after the last RX byte before o_CS_n rises (range 1..15).
TIMEOUT, 1023, maximum cycles to wait for i_RXdv per byte before aborting.

Ports:
i_FPGA_clk  in  1  system clock
i_FPGA_rst  in  1  asynchronous active-low reset
i_req_valid  in  1  request present
i_req_write  in  1  1 = write, 0 = read
i_req_addr  in  4  register address
i_req_data  in  16  write data; ignored for reads
o_req_ready  out  1  high only in IDLE
o_TXByte  out  8  byte to the SPI byte engine
o_TXdv  out  1  one-cycle strobe to send o_TXByte
i_TX_ready  in  1  byte engine idle and able to accept a byte
i_RXByte  in  8  byte received by the engine
i_RXdv  in  1  one-cycle strobe that i_RXByte is valid
o_CS_n  out  1  slave chip select, active low
o_rsp_valid  out  1  one-cycle pulse at the end of a frame
o_rsp_echo  out  8  RX byte slot 1 (previous frame's CMDADDR)
o_rsp_data  out  16  {RX slot 2, RX slot 3}
o_rsp_err  out  1  timeout flag, valid with o_rsp_valid

Behaviour:
- Clock and reset: one clock, i_FPGA_clk. Reset is asynchronous and active-low on i_FPGA_rst.
- Reset values: o_CS_n=1, o_TXdv=0, o_TXByte=0, o_req_ready=1, o_rsp_valid=0, o_rsp_echo=0, o_rsp_data=0, o_rsp_err=0. State returns to IDLE.
- Reset mid-frame: the frame is abandoned and CS rises immediately (asynchronously). No response is produced.
- States: IDLE, SETUP, SEND, WAITRX, HOLD, DONE.
- IDLE: o_req_ready=1.
  - On i_req_valid, latch the request.
  - Latched CMDADDR = {write ? 4'h0 : READ_NIB, addr}.
  - Latched data = write ? i_req_data : 16'h0000.
  - Set byte index to 0, drive o_CS_n=0, go to SETUP.
  - o_req_ready drops the cycle after acceptance.
- SETUP: count CS_SETUP cycles, then go to SEND.
- SEND: wait for i_TX_ready.
  - When it is high, drive o_TXByte from the slot: 0=SYNC_BYTE, 1=CMDADDR, 2=data[15:8], 3=data[7:0].
  - Pulse o_TXdv for exactly one cycle, clear the timeout counter, go to WAITRX.
  - o_TXByte holds its value until the next send.
- WAITRX: on i_RXdv, store i_RXByte into RX slot[index].
  - If index=3, go to HOLD; otherwise increment index and go to SEND.
  - i_RXdv outside WAITRX is ignored.
  - The timeout counter increments every cycle without i_RXdv.
  - When the counter reaches TIMEOUT, set the err flag, skip the remaining bytes and go to HOLD.
- HOLD: count CS_HOLD cycles, raise o_CS_n, go to DONE.
- DONE: pulse o_rsp_valid for one cycle.
  - o_rsp_echo and o_rsp_data are registered from the RX slots and hold until the next DONE.
  - On error, unreceived slots read 0 and o_rsp_err=1; otherwise o_rsp_err=0.
  - Go to IDLE.
- o_CS_n is low continuously from SETUP through HOLD. CS is never released between bytes.
- o_TXdv is never asserted while i_TX_ready=0 or outside SEND.
- Back-to-back requests: i_req_valid held high starts the next frame on the cycle after DONE. CS is high for at least 2 cycles (DONE plus the IDLE acceptance cycle).
- Minimum frame latency with immediate ready and RX: acceptance to o_rsp_valid = 1 + CS_SETUP + 4×(1 + RX latency) + CS_HOLD + 1 cycles.
- Counters saturate and never wrap. The byte index is 2 bits.

Decomposition:
- Shared package holds:
  - state enum;
  - CMD_WRITE_NIB = 4'h0;
  - default READ_NIB;
  - FRAME_BYTES = 4;
  - slot index constants.
- One sub-module, spi_frame_timer: a loadable down-counter with a done flag. It is reused for the SETUP/HOLD delays and the RX timeout.

Test Plan:
- Write: request addr=3, data=16'hA55A with a byte-engine model giving RX 2 cycles after o_TXdv -> TX sequence 8'h00, 8'h03, 8'hA5, 8'h5A; CS low throughout; one o_rsp_valid with o_rsp_err=0.
- Read: request addr=5; slave model returns 8'h00, 8'h03, 8'h12, 8'h34 -> TX sequence 8'h00, 8'hF5, 8'h00, 8'h00; o_rsp_echo=8'h03; o_rsp_data=16'h1234.
- Backpressure: hold i_TX_ready low for 20 cycles before slot 2 -> no o_TXdv during the stall; slot 2 sent exactly once when ready rises; CS stays low.
- Timeout: suppress i_RXdv after slot 1 -> o_rsp_valid with o_rsp_err=1 and o_rsp_data=0 after TIMEOUT cycles; CS high; o_req_ready returns high.
- Back-to-back: two queued requests (write addr 1, read addr 1) -> two complete frames; CS high at least 2 cycles between them; the second response echo equals 8'h01.
- Reset mid-frame: assert i_FPGA_rst low during slot 2 -> o_CS_n=1 and o_TXdv=0 asynchronously; no o_rsp_valid; after release, a fresh request completes normally.
